// File: rtl/scv_pkg.sv
// Shared video types and constants for the epochtv1 / scv video output path.
package scv_pkg;

    // One 24-bit pixel, red in the most significant byte.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // CE ticks without an HS rising edge before the input is declared lost.
    localparam int unsigned NOSIG_CE_DEFAULT = 1024;

    // Pass a pixel through when keep is set, otherwise return black.
    function automatic rgb888_t rgb_gate(input rgb888_t px, input logic keep);
        rgb888_t res;
        if (keep) begin
            res = px;
        end else begin
            res = rgb888_t'(24'd0);
        end
        return res;
    endfunction

endpackage

// File: rtl/scv_vidout_if.sv
// Video stream interface: epochtv1 side inputs and registered display outputs.
interface scv_vidout_if import scv_pkg::*; #(
    parameter int MEAS_W = 9
) ();
    logic              CE;
    logic              DE;
    logic              HS;
    logic              VS;
    rgb888_t           RGB;
    logic              CE_PIX;
    logic [7:0]        R;
    logic [7:0]        G;
    logic [7:0]        B;
    logic              HSYNC;
    logic              VSYNC;
    logic              HBLANK;
    logic              VBLANK;
    logic [MEAS_W-1:0] ACT_W;
    logic [MEAS_W-1:0] ACT_H;
    logic              FIELD;
    logic              NOSIG;

    // Source side: drives the pixel stream, observes the formatted output.
    modport master (
        output CE, DE, HS, VS, RGB,
        input  CE_PIX, R, G, B, HSYNC, VSYNC, HBLANK, VBLANK,
        input  ACT_W, ACT_H, FIELD, NOSIG
    );

    // Output block side.
    modport slave (
        input  CE, DE, HS, VS, RGB,
        output CE_PIX, R, G, B, HSYNC, VSYNC, HBLANK, VBLANK,
        output ACT_W, ACT_H, FIELD, NOSIG
    );
endinterface

// File: rtl/scv_vidout_meas.sv
// Timing measurement: HS/VS edge detection, line/frame counters, active
// width/height capture, vertical blanking, field toggle and signal-loss watch.
module scv_vidout_meas import scv_pkg::*; #(
    parameter int MEAS_W   = 9,
    parameter int NOSIG_CE = NOSIG_CE_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ce_i,
    input  logic              de_i,
    input  logic              hs_i,
    input  logic              vs_i,
    output logic              nosig_next_o,
    output logic              vblank_o,
    output logic              field_o,
    output logic              nosig_o,
    output logic [MEAS_W-1:0] act_w_o,
    output logic [MEAS_W-1:0] act_h_o
);
    // The horizontal position counter doubles as the signal-loss timer: both
    // count CE ticks since the last HS rising edge and saturate.
    localparam int                CNT_W     = $clog2(NOSIG_CE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  NOSIG_LIM = CNT_W'(NOSIG_CE);
    localparam logic [MEAS_W-1:0] MEAS_MAX  = {MEAS_W{1'b1}};
    localparam logic [MEAS_W-1:0] MEAS_ZERO = {MEAS_W{1'b0}};

    logic              hs_prev_q, hs_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic              seen_hs_q, seen_hs_d;
    logic              seen_vs_q, seen_vs_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [MEAS_W-1:0] linepix_q, linepix_d;
    logic [MEAS_W-1:0] actlines_q, actlines_d;
    logic [MEAS_W-1:0] act_w_q, act_w_d;
    logic [MEAS_W-1:0] act_h_q, act_h_d;
    logic              vblank_q, vblank_d;
    logic              vblank_out_q, vblank_out_d;
    logic              field_q, field_d;
    logic              nosig_q, nosig_d;

    logic              hs_rise_s;
    logic              vs_rise_s;
    logic              line_done_s;
    logic [MEAS_W-1:0] actlines_mid_s;

    // A line only counts once a full HS-to-HS interval has been observed.
    assign hs_rise_s   = ce_i & hs_i & ~hs_prev_q;
    assign vs_rise_s   = ce_i & vs_i & ~vs_prev_q;
    assign line_done_s = hs_rise_s & seen_hs_q & (linepix_q != MEAS_ZERO);

    // Next-state for all measurement state; the line is closed before the frame
    // so a simultaneous HS+VS still counts the final line.
    always_comb begin
        hs_prev_d      = hs_prev_q;
        vs_prev_d      = vs_prev_q;
        seen_hs_d      = seen_hs_q;
        seen_vs_d      = seen_vs_q;
        hcnt_d         = hcnt_q;
        linepix_d      = linepix_q;
        actlines_d     = actlines_q;
        act_w_d        = act_w_q;
        act_h_d        = act_h_q;
        vblank_d       = vblank_q;
        vblank_out_d   = vblank_out_q;
        field_d        = field_q;
        nosig_d        = nosig_q;
        actlines_mid_s = actlines_q;
        if (ce_i) begin
            hs_prev_d = hs_i;
            vs_prev_d = vs_i;

            if (hs_rise_s) begin
                hcnt_d = CNT_W'(0);
            end else if (hcnt_q != CNT_MAX) begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end else begin
                hcnt_d = hcnt_q;
            end
            nosig_d = (hcnt_d >= NOSIG_LIM);

            if (de_i) begin
                vblank_d = 1'b0;
            end else if (hs_rise_s && (linepix_q == MEAS_ZERO)) begin
                vblank_d = 1'b1;
            end else begin
                vblank_d = vblank_q;
            end

            if (hs_rise_s) begin
                seen_hs_d = 1'b1;
                linepix_d = de_i ? MEAS_W'(1) : MEAS_ZERO;
                if (line_done_s) begin
                    act_w_d        = linepix_q;
                    actlines_mid_s = (actlines_q != MEAS_MAX) ? (actlines_q + MEAS_W'(1)) : actlines_q;
                end else begin
                    act_w_d        = act_w_q;
                end
            end else if (de_i && (linepix_q != MEAS_MAX)) begin
                linepix_d = linepix_q + MEAS_W'(1);
            end else begin
                linepix_d = linepix_q;
            end

            if (vs_rise_s) begin
                seen_vs_d  = 1'b1;
                field_d    = ~field_q;
                actlines_d = MEAS_ZERO;
                if (seen_vs_q && (actlines_mid_s != MEAS_ZERO)) begin
                    act_h_d = actlines_mid_s;
                end else begin
                    act_h_d = act_h_q;
                end
            end else begin
                actlines_d = actlines_mid_s;
            end

            vblank_out_d = vblank_d | nosig_d;
        end else begin
            nosig_d = nosig_q;
        end
    end

    // Measurement state register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            seen_hs_q    <= 1'b0;
            seen_vs_q    <= 1'b0;
            hcnt_q       <= CNT_W'(0);
            linepix_q    <= MEAS_ZERO;
            actlines_q   <= MEAS_ZERO;
            act_w_q      <= MEAS_ZERO;
            act_h_q      <= MEAS_ZERO;
            vblank_q     <= 1'b1;
            vblank_out_q <= 1'b1;
            field_q      <= 1'b0;
            nosig_q      <= 1'b0;
        end else begin
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            seen_hs_q    <= seen_hs_d;
            seen_vs_q    <= seen_vs_d;
            hcnt_q       <= hcnt_d;
            linepix_q    <= linepix_d;
            actlines_q   <= actlines_d;
            act_w_q      <= act_w_d;
            act_h_q      <= act_h_d;
            vblank_q     <= vblank_d;
            vblank_out_q <= vblank_out_d;
            field_q      <= field_d;
            nosig_q      <= nosig_d;
        end
    end

    assign nosig_next_o = nosig_d;
    assign vblank_o     = vblank_out_q;
    assign field_o      = field_q;
    assign nosig_o      = nosig_q;
    assign act_w_o      = act_w_q;
    assign act_h_o      = act_h_q;

endmodule

// File: rtl/scv_vidout.sv
// Video output stage: registers the epochtv1 pixel stream one CLK after each
// CE, blanks pixels outside DE or while the input timing is lost, and reports
// measured timing from the measurement sub-block.
module scv_vidout import scv_pkg::*; #(
    parameter int MEAS_W   = 9,
    parameter int NOSIG_CE = NOSIG_CE_DEFAULT
) (
    input  logic         CLK,
    input  logic         RESB,
    scv_vidout_if.slave  vif
);
    logic    ce_pix_q, ce_pix_d;
    rgb888_t pix_q, pix_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    hblank_q, hblank_d;

    logic              nosig_next_s;
    logic              vblank_s;
    logic              field_s;
    logic              nosig_s;
    logic [MEAS_W-1:0] act_w_s;
    logic [MEAS_W-1:0] act_h_s;

    scv_vidout_meas #(
        .MEAS_W   (MEAS_W),
        .NOSIG_CE (NOSIG_CE)
    ) u_meas (
        .clk_i        (CLK),
        .rst_ni       (RESB),
        .ce_i         (vif.CE),
        .de_i         (vif.DE),
        .hs_i         (vif.HS),
        .vs_i         (vif.VS),
        .nosig_next_o (nosig_next_s),
        .vblank_o     (vblank_s),
        .field_o      (field_s),
        .nosig_o      (nosig_s),
        .act_w_o      (act_w_s),
        .act_h_o      (act_h_s)
    );

    // Pixel path next-state: load on CE, hold between strobes. The loss flag
    // used here is the one being registered on this same edge so the blanking
    // lines up with NOSIG.
    always_comb begin
        ce_pix_d = vif.CE;
        pix_d    = pix_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblank_d = hblank_q;
        if (vif.CE) begin
            pix_d    = rgb_gate(vif.RGB, vif.DE & ~nosig_next_s);
            hsync_d  = vif.HS;
            vsync_d  = vif.VS;
            hblank_d = ~vif.DE | nosig_next_s;
        end else begin
            pix_d    = pix_q;
            hblank_d = hblank_q;
        end
    end

    // Pixel path register with asynchronous reset.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            ce_pix_q <= 1'b0;
            pix_q    <= rgb888_t'(24'd0);
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b1;
        end else begin
            ce_pix_q <= ce_pix_d;
            pix_q    <= pix_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
        end
    end

    assign vif.CE_PIX = ce_pix_q;
    assign vif.R      = pix_q.r;
    assign vif.G      = pix_q.g;
    assign vif.B      = pix_q.b;
    assign vif.HSYNC  = hsync_q;
    assign vif.VSYNC  = vsync_q;
    assign vif.HBLANK = hblank_q;
    assign vif.VBLANK = vblank_s;
    assign vif.ACT_W  = act_w_s;
    assign vif.ACT_H  = act_h_s;
    assign vif.FIELD  = field_s;
    assign vif.NOSIG  = nosig_s;

endmodule

// File: tb/tb_scv_vidout.sv
// Bench for scv_vidout: CE at 1-in-7 CLK, a line/frame reference model fills a
// scoreboard queue at each CE, and a monitor compares on every CE_PIX.
module tb_scv_vidout;
    import scv_pkg::*;

    localparam int MEAS_W   = 9;
    localparam int MEAS_MAX = 511;
    localparam int NOSIG_CE = 1024;

    logic CLK  = 1'b0;
    logic RESB = 1'b0;

    always #5 CLK = ~CLK;

    scv_vidout_if #(.MEAS_W(MEAS_W)) vif ();

    scv_vidout #(.MEAS_W(MEAS_W), .NOSIG_CE(NOSIG_CE)) dut (
        .CLK  (CLK),
        .RESB (RESB),
        .vif  (vif)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        hsync;
        logic        vsync;
        logic        hblank;
        logic        vblank;
        logic [8:0]  act_w;
        logic [8:0]  act_h;
        logic        field;
        logic        nosig;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;
    int   hbl_low_cnt = 0;

    // Reference model state (plain integers, rule level)
    bit m_hs, m_vs, m_seen_hs, m_seen_vs, m_vblank, m_field;
    int m_cnt, m_linepix, m_lines, m_act_w, m_act_h;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.hblank = 1'b1;
        e.vblank = 1'b1;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t e;
        e.rgb    = {vif.R, vif.G, vif.B};
        e.hsync  = vif.HSYNC;
        e.vsync  = vif.VSYNC;
        e.hblank = vif.HBLANK;
        e.vblank = vif.VBLANK;
        e.act_w  = vif.ACT_W;
        e.act_h  = vif.ACT_H;
        e.field  = vif.FIELD;
        e.nosig  = vif.NOSIG;
        return e;
    endfunction

    task automatic check_outs(input string name, input exp_t e);
        exp_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, a, e);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_hs = 0; m_vs = 0; m_seen_hs = 0; m_seen_vs = 0;
        m_vblank = 1; m_field = 0;
        m_cnt = 0; m_linepix = 0; m_lines = 0; m_act_w = 0; m_act_h = 0;
        exp_q.delete();
        last_exp = reset_exp();
    endtask

    // Apply the line/frame rules to one CE sample and queue the expected output.
    task automatic model_step(input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
        bit   hs_rise, vs_rise, nosig;
        exp_t e;
        hs_rise = hs && !m_hs;
        vs_rise = vs && !m_vs;
        m_hs = hs;
        m_vs = vs;
        m_cnt = hs_rise ? 0 : imin(m_cnt + 1, NOSIG_CE);
        nosig = (m_cnt >= NOSIG_CE);
        if (de) m_vblank = 0;
        else if (hs_rise && m_linepix == 0) m_vblank = 1;
        if (hs_rise) begin
            if (m_seen_hs && m_linepix > 0) begin
                m_act_w = m_linepix;
                m_lines = imin(m_lines + 1, MEAS_MAX);
            end
            m_linepix = de ? 1 : 0;
            m_seen_hs = 1;
        end else if (de) begin
            m_linepix = imin(m_linepix + 1, MEAS_MAX);
        end
        if (vs_rise) begin
            if (m_seen_vs && m_lines > 0) m_act_h = m_lines;
            m_lines = 0;
            m_field = !m_field;
            m_seen_vs = 1;
        end
        e.rgb    = (de && !nosig) ? rgb : 24'h000000;
        e.hsync  = hs;
        e.vsync  = vs;
        e.hblank = !de || nosig;
        e.vblank = m_vblank || nosig;
        e.act_w  = 9'(m_act_w);
        e.act_h  = 9'(m_act_h);
        e.field  = m_field;
        e.nosig  = nosig;
        exp_q.push_back(e);
    endtask

    // One CE strobe followed by six idle CLKs carrying junk pixel data.
    task automatic ce_tick(input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
        @(negedge CLK);
        vif.CE  = 1'b1;
        vif.DE  = de;
        vif.HS  = hs;
        vif.VS  = vs;
        vif.RGB = rgb;
        model_step(de, hs, vs, rgb);
        @(negedge CLK);
        vif.CE  = 1'b0;
        vif.DE  = 1'($urandom);
        vif.RGB = 24'($urandom);
        repeat (5) @(negedge CLK);
    endtask

    // Line starting with a one-CE HS pulse (optionally with VS), then blanking, then active.
    task automatic send_line(input int blank, input int act, input bit vs);
        ce_tick(1'b0, 1'b1, vs, 24'($urandom));
        for (int i = 1; i < blank; i++) ce_tick(1'b0, 1'b0, 1'b0, 24'($urandom));
        for (int i = 0; i < act; i++) ce_tick(1'b1, 1'b0, 1'b0, 24'($urandom));
    endtask

    // Scoreboard monitor: compare at every CE_PIX, check hold in between.
    always @(negedge CLK) begin
        if (RESB) begin
            if (vif.CE_PIX) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ce_pix @%0t: got CE_PIX=1, required no pending pixel", $time);
                end else begin
                    last_exp = exp_q.pop_front();
                    check_outs("pix", last_exp);
                    if (!vif.HBLANK) hbl_low_cnt++;
                end
            end else begin
                check_outs("hold", last_exp);
            end
        end
    end

    initial begin
        vif.CE = 1'b0; vif.DE = 1'b0; vif.HS = 1'b0; vif.VS = 1'b0; vif.RGB = 24'd0;
        model_reset();
        #20;
        check_outs("reset_state", reset_exp());
        check_int("reset_ce_pix", int'(vif.CE_PIX), 0);
        @(negedge CLK);
        #2 RESB = 1'b1;

        // Single line measurement: 40 blank + 256 active
        send_line(40, 10, 1'b0);
        hbl_low_cnt = 0;
        send_line(40, 256, 1'b0);
        check_int("hblank_low_count", hbl_low_cnt, 256);
        ce_tick(1'b0, 1'b1, 1'b0, 24'h123456);
        check_int("act_w_256", int'(vif.ACT_W), 256);

        // Width saturation, then the first VS (partial frame, nothing loaded)
        for (int i = 0; i < 520; i++) ce_tick(1'b1, 1'b0, 1'b0, 24'($urandom));
        send_line(1, 3, 1'b1);
        check_int("act_w_sat", int'(vif.ACT_W), MEAS_MAX);
        check_int("act_h_first_vs", int'(vif.ACT_H), 0);

        // Frame: 222 active lines, 40 blank lines
        for (int i = 1; i < 222; i++) send_line(1, 3, 1'b0);
        send_line(5, 0, 1'b0);
        check_int("vblank_first_blank", int'(vif.VBLANK), 0);
        send_line(5, 0, 1'b0);
        check_int("vblank_set", int'(vif.VBLANK), 1);
        for (int i = 2; i < 40; i++) send_line(5, 0, 1'b0);
        send_line(1, 3, 1'b1);
        check_int("act_h_222", int'(vif.ACT_H), 222);
        check_int("field_after_2vs", int'(vif.FIELD), 0);
        check_int("vblank_cleared", int'(vif.VBLANK), 0);

        // HS and VS on the same CE straight after the last of 223 active lines
        for (int i = 1; i < 223; i++) send_line(1, 3, 1'b0);
        send_line(1, 3, 1'b1);
        check_int("act_h_223", int'(vif.ACT_H), 223);
        check_int("field_after_3vs", int'(vif.FIELD), 1);

        // Randomized stream against the model
        for (int i = 0; i < 800; i++)
            ce_tick(1'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0), 24'($urandom));

        // Signal loss
        ce_tick(1'b0, 1'b0, 1'b0, 24'd0);
        ce_tick(1'b1, 1'b1, 1'b0, 24'($urandom));
        for (int i = 0; i < 1023; i++) ce_tick(1'b1, 1'b0, 1'b0, 24'($urandom));
        check_int("nosig_before_limit", int'(vif.NOSIG), 0);
        ce_tick(1'b1, 1'b0, 1'b0, 24'hABCDEF);
        check_int("nosig_at_limit", int'(vif.NOSIG), 1);
        check_int("nosig_rgb_black", int'({vif.R, vif.G, vif.B}), 0);
        check_int("nosig_hblank", int'(vif.HBLANK), 1);
        check_int("nosig_vblank", int'(vif.VBLANK), 1);
        for (int i = 0; i < 75; i++) ce_tick(1'b1, 1'b0, 1'b0, 24'($urandom));
        ce_tick(1'b0, 1'b0, 1'b0, 24'd0);
        ce_tick(1'b1, 1'b1, 1'b0, 24'($urandom));
        check_int("nosig_cleared", int'(vif.NOSIG), 0);

        // Reset pulsed mid-line, right while CE_PIX is high
        send_line(5, 20, 1'b0);
        ce_tick(1'b0, 1'b1, 1'b0, 24'd0);
        for (int i = 0; i < 60; i++) ce_tick(1'b1, 1'b0, 1'b0, 24'($urandom));
        @(negedge CLK);
        vif.CE = 1'b1; vif.DE = 1'b1; vif.RGB = 24'hFFFFFF;
        @(posedge CLK);
        #2 RESB = 1'b0;
        #1;
        check_int("reset_mid_ce_pix", int'(vif.CE_PIX), 0);
        check_outs("reset_mid_state", reset_exp());
        model_reset();
        @(negedge CLK);
        vif.CE = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RESB = 1'b1;
        for (int i = 0; i < 40; i++) ce_tick(1'b1, 1'b0, 1'b0, 24'($urandom));
        send_line(5, 200, 1'b0);
        check_int("act_w_partial_discarded", int'(vif.ACT_W), 0);
        ce_tick(1'b0, 1'b1, 1'b0, 24'd0);
        check_int("act_w_after_reset", int'(vif.ACT_W), 200);

        repeat (3) @(negedge CLK);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scv_vidout.md
SCV_VIDOUT -- requirements
Module: scv_vidout

Interface
REQ-001 Parameters SHALL be: MEAS_W, default 9, width of position counters and measurement outputs; NOSIG_CE, default 1024, number of CE ticks without an HS rising edge before NOSIG is raised.
REQ-002 CLK  input  1  system clock, 2x 14.318181 MHz, shared with epochtv1.
REQ-003 RESB  input  1  asynchronous, active-low reset.
REQ-004 CE  input  1  pixel enable, one CLK wide, same strobe that drives epochtv1.
REQ-005 DE, HS, VS  input  1 each  epochtv1 data enable and syncs, active high, sampled only on CE.
REQ-006 RGB  input  24  epochtv1 pixel, {R,G,B}, sampled only on CE.
REQ-007 CE_PIX  output  1  pixel strobe, CE delayed one CLK.
REQ-008 R, G, B  output  8 each  registered pixel, forced to 0 when DE sampled 0.
REQ-009 HSYNC, VSYNC  output  1 each  registered HS/VS.
REQ-010 HBLANK, VBLANK  output  1 each  blanking flags.
REQ-011 ACT_W, ACT_H  output  MEAS_W each  measured active width (pixels) and height (lines).
REQ-012 FIELD  output  1  toggles once per frame.
REQ-013 NOSIG  output  1  input timing lost.

Function
REQ-014 All pixel outputs SHALL update only on CLK edges where CE=1 and hold otherwise; latency input sample -> output is 1 CLK, aligned with CE_PIX.
REQ-015 HBLANK SHALL equal the inverse of the sampled DE.
REQ-016 HS rising edge SHALL be detected as sampled HS=1 with previous sampled HS=0; VS likewise.
REQ-017 hcnt SHALL increment per CE and clear on the HS rising edge; it saturates at all-ones, with no wrap.
REQ-018 linepix SHALL count CE ticks with DE=1; on HS rising edge, if linepix is nonzero, ACT_W SHALL load linepix; linepix then clears.
REQ-019 actlines SHALL increment on each HS rising edge that ends a line with linepix nonzero; on VS rising edge, ACT_H SHALL load actlines if it is nonzero, then actlines clears.
REQ-020 VBLANK SHALL set on an HS rising edge ending a line with linepix=0, and clear on the first CE with DE=1; if both occur on one CE, clear wins.
REQ-021 Simultaneous HS and VS rising edges on one CE SHALL apply REQ-018 before REQ-019, so the final line is counted.
REQ-022 FIELD SHALL toggle on every VS rising edge.
REQ-023 nosig counter SHALL increment per CE, clear on HS rising edge, and saturate; NOSIG=1 while the counter is >= NOSIG_CE; NOSIG clears on the next HS rising edge.
REQ-024 While NOSIG=1, R, G and B SHALL be 0, and HBLANK and VBLANK SHALL be 1.
REQ-025 Measurement values SHALL saturate at 2^MEAS_W-1 rather than wrap.

Reset
REQ-026 On RESB=0, asynchronously: CE_PIX=0, R=G=B=0, HSYNC=VSYNC=0, HBLANK=VBLANK=1, ACT_W=ACT_H=0, FIELD=0, NOSIG=0, and all counters and edge history = 0.
REQ-027 Reset asserted mid-line or mid-frame SHALL discard the partial line and frame; the first ACT_W after release comes from the first complete HS-to-HS line.

Structure
REQ-028 scv_pkg SHALL hold the rgb888 typedef (r, g, b fields) and a NOSIG_CE_DEFAULT constant, shared with epochtv1.
REQ-029 One sub-module, scv_vidout_meas, SHALL hold edge detection, counters and the ACT_W/ACT_H/NOSIG logic; the pixel register path stays in the top module.

Verification
REQ-030 The bench SHALL drive CE as 1-in-7 CLK, as the render bench does, with the epochtv1 output stream; and CE_PIX, R, G and B SHALL match the input one CLK later; pixels with DE=0 read 000000.
REQ-031 Synthetic line: 40 CE of DE=0, then 256 CE of DE=1, HS pulse -> ACT_W=256 after the HS edge; HBLANK low for exactly 256 CE_PIX.
REQ-032 Frame: 222 lines with DE, 40 blank lines, VS -> ACT_H=222; VBLANK rises at the first blank-line HS and falls on the first DE of the next frame; FIELD toggles.
REQ-033 HS and VS rising on the same CE after the last active line -> ACT_H counts that line (223 when 223 lines are active).
REQ-034 Stop HS for 1100 CE -> NOSIG=1 at CE 1024; RGB=0 and HBLANK=VBLANK=1; next HS clears NOSIG.
REQ-035 RESB pulsed low mid-line -> all outputs at reset values immediately; the first complete line after release yields the correct ACT_W.
